// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 serial receiver, 16x oversampled, with bus-readable status.
// Optional even-parity bit and parity_err output when SPART_RX_PARITY_EN is defined.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
`ifdef SPART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef SPART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  localparam logic [TW-1:0] MID_BIT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TCK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_m;
  logic                 rxd_s;
  logic                 rd;

  assign rd = iocs & iorw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;

      // Clearing reads come first so a flag set later in this block on the same edge wins.
      if (rd && ioaddr == 2'b00) begin
        rda <= 1'b0;
      end
      if (rd && ioaddr == 2'b01) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      if (en) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == MID_BIT) begin
              if (!rxd_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == LAST_TCK) begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
`ifdef SPART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
`ifdef SPART_RX_PARITY_EN
          PARITY: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == LAST_TCK) begin
              if (^shreg ^ rxd_s) begin
                parity_err <= 1'b1;
              end
              state <= STOP;
            end
          end
`endif
          STOP: begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == LAST_TCK) begin
              if (rxd_s) begin
                rx_data <= shreg;
                if (rda) begin
                  overrun <= 1'b1;
                end
                rda <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx with a frame-level reference model.
// Builds with or without SPART_RX_PARITY_EN.
module tb_spart_rx;

  typedef struct {
    logic [11:0] v;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rxd;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;
  logic       pe_dut;

  int tests = 0;
  int fails = 0;

  // Model of the visible registers: {rx_data, rda, frame_err, overrun, parity_err}
  logic [11:0] m = '0;
  exp_t        q[$];
  exp_t        e;
  logic [11:0] cur;
  logic [11:0] prev;
  logic        mon_en = 1'b0;

`ifdef SPART_RX_PARITY_EN
  logic parity_err;
  assign pe_dut = parity_err;
`else
  assign pe_dut = 1'b0;
`endif

  spart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rxd       (rxd),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
`ifdef SPART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
    end
  end

  // Monitor: every visible output change must match the next expected snapshot.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {rx_data, rda, frame_err, overrun, pe_dut};
      if (cur !== prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change got=%h expected=no change", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.v) begin
            fails++;
            $display("FAIL %s got data=%h rda=%b fe=%b ov=%b pe=%b expected data=%h rda=%b fe=%b ov=%b pe=%b",
                     e.nm, cur[11:4], cur[3], cur[2], cur[1], cur[0],
                     e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push(input logic [11:0] nv, input string nm);
    exp_t x;
    if (nv != m) begin
      x.v  = nv;
      x.nm = nm;
      q.push_back(x);
    end
    m = nv;
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (en) c++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip,
                            input string nm);
    logic [11:0] nv;
    nv = m;
`ifdef SPART_RX_PARITY_EN
    if (par_flip) begin
      nv[0] = 1'b1;
      push(nv, {nm, "_parity"});
    end
`endif
    if (stop_ok) begin
      if (nv[3]) nv[1] = 1'b1;
      nv[3]    = 1'b1;
      nv[11:4] = d;
    end else begin
      nv[2] = 1'b1;
    end
    push(nv, nm);

    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
`ifdef SPART_RX_PARITY_EN
    rxd = ^d ^ par_flip;
    wait_ticks(16);
`else
    if (par_flip) rxd = 1'b1;
`endif
    if (stop_ok) begin
      rxd = 1'b1;
      wait_ticks(20);
    end else begin
      // Low stop bit lingers past the sample point, so a false start follows.
      rxd = 1'b0;
      wait_ticks(12);
      rxd = 1'b1;
      wait_ticks(24);
    end
  endtask

  task automatic bus_op(input logic rw, input logic [1:0] addr, input string nm);
    logic [11:0] nv;
    nv = m;
    if (rw && addr == 2'b00) nv[3] = 1'b0;
    if (rw && addr == 2'b01) nv[2:0] = 3'b000;
    push(nv, nm);
    iocs   = 1'b1;
    iorw   = rw;
    ioaddr = addr;
    @(posedge clk);
    #1;
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
    wait_ticks(2);
  endtask

  task automatic check_now(input logic [11:0] exp, input string nm);
    logic [11:0] got;
    got = {rx_data, rda, frame_err, overrun, pe_dut};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       so;
    logic       pf;
    int         op;
    rst = 1'b1; rxd = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_now(12'h000, "reset_state");
    prev   = {rx_data, rda, frame_err, overrun, pe_dut};
    mon_en = 1'b1;
    wait_ticks(4);

    send_frame(8'hA5, 1'b1, 1'b0, "rx_A5");
    bus_op(1'b1, 2'b00, "read_data_clears_rda");
    rxd = 1'b0; wait_ticks(4); rxd = 1'b1; wait_ticks(20);
    check_now(m, "false_start_no_change");
    send_frame(8'h3C, 1'b1, 1'b0, "rx_3C");
    bus_op(1'b1, 2'b00, "read_data_3C");
    send_frame(8'h55, 1'b0, 1'b0, "frame_err_55");
    bus_op(1'b1, 2'b01, "read_status_clears_fe");
    send_frame(8'h11, 1'b1, 1'b0, "rx_11");
    send_frame(8'h22, 1'b1, 1'b0, "rx_22_overrun");
    bus_op(1'b0, 2'b00, "write_ignored");
    bus_op(1'b1, 2'b10, "addr2_ignored");

    // Reset in the middle of data bit 4 of 0xFF.
    rxd = 1'b0; wait_ticks(16);
    rxd = 1'b1; wait_ticks(4 * 16 + 8);
    push(12'h000, "mid_frame_reset");
    rst = 1'b1; repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_now(12'h000, "after_reset_outputs");
    wait_ticks(20);
    send_frame(8'h81, 1'b1, 1'b0, "rx_81");
    bus_op(1'b1, 2'b00, "read_81");

`ifdef SPART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, "parity_bad_07");
    bus_op(1'b1, 2'b01, "read_status_clears_pe");
    send_frame(8'h07, 1'b1, 1'b0, "parity_good_07");
    check_now(m, "parity_good_no_pe");
    bus_op(1'b1, 2'b00, "read_07");
`endif

    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom);
      so = ($urandom_range(0, 4) != 0);
      pf = 1'b0;
`ifdef SPART_RX_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`endif
      send_frame(d, so, pf, "rand_frame");
      op = $urandom_range(0, 4);
      case (op)
        1: bus_op(1'b1, 2'b00, "rand_read_data");
        2: bus_op(1'b1, 2'b01, "rand_read_status");
        3: bus_op(1'b0, 2'($urandom), "rand_write");
        4: bus_op(1'b1, 2'($urandom_range(2, 3)), "rand_read_hi");
        default: wait_ticks(2);
      endcase
    end

    wait_ticks(8);
    check_now(m, "final_state");
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations got=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
